// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, bps_select encoding and receiver FSM states.
package uart_pkg;

    // Width of the bit-period counter; holds the slowest divisor (5000).
    localparam int unsigned CNT_W = 14;

    // clk cycles per bit on the 24 MHz system clock.
    localparam int unsigned BAUD_DIV_115200 = 208;
    localparam int unsigned BAUD_DIV_9600   = 2500;
    localparam int unsigned BAUD_DIV_4800   = 5000;

    // bps_select encoding; 2'd3 also selects 4800.
    localparam logic [1:0] BPS_115200 = 2'd0;
    localparam logic [1:0] BPS_9600   = 2'd1;
    localparam logic [1:0] BPS_4800   = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input plus a falling-edge detector.
// All stages reset high so an idle-high line produces no edge out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic line,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Next-state of the shift chain.
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchroniser chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign line = s2_q;
    assign fall = s3_q & ~s2_q;

endmodule

// File: rtl/uart_rx_driver.sv
// 8N1 UART receiver: start-bit validation at half a bit, mid-bit data sampling LSB first,
// registered byte output with one-cycle valid / framing-error strobes.
module uart_rx_driver
    import uart_pkg::*;
#(
    parameter int unsigned DIV_115200 = BAUD_DIV_115200,
    parameter int unsigned DIV_9600   = BAUD_DIV_9600,
    parameter int unsigned DIV_4800   = BAUD_DIV_4800
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic [1:0] bps_select,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    logic             line;
    logic             fall;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_frame_err_q, rx_frame_err_d;
    logic             rx_busy_q, rx_busy_d;

    logic [CNT_W-1:0] div_sel;
    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] half_m1;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (uart_rx),
        .line  (line),
        .fall  (fall)
    );

    // Decode the requested bit period; only latched when a frame starts.
    always_comb begin
        case (bps_select)
            BPS_115200: div_sel = CNT_W'(DIV_115200);
            BPS_9600:   div_sel = CNT_W'(DIV_9600);
            default:    div_sel = CNT_W'(DIV_4800);
        endcase
    end

    assign div_m1  = div_q - CNT_W'(1);
    assign half_m1 = (div_q >> 1) - CNT_W'(1);

    // Receiver FSM: next state, bit timing, shifting and output strobes.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        div_d          = div_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Edge-triggered so a held-low (break) line never retriggers.
                if (fall) begin
                    cnt_d   = '0;
                    div_d   = div_sel;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == half_m1) begin
                    if (!line) begin
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                        state_d   = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (cnt_q == div_m1) begin
                    shift_d   = {line, shift_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (cnt_q == div_m1) begin
                    if (line) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_frame_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        rx_busy_d = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            div_q          <= CNT_W'(DIV_115200);
            bit_idx_q      <= 3'd0;
            shift_q        <= 8'h00;
            rx_data_q      <= 8'h00;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_driver.sv
// Directed bench for uart_rx_driver: serial frames driven on negedges, strobes logged on negedges.
// The slower divisors are shortened so the run stays small; 115200 keeps its real value of 208.
module tb_uart_rx_driver;

    localparam int D0 = 208;
    localparam int D1 = 500;
    localparam int D2 = 700;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [1:0] bps_select = 2'd0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         both_hi = 0;
    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         e_cyc[$];
    int         t;

    uart_rx_driver #(
        .DIV_115200 (D0),
        .DIV_9600   (D1),
        .DIV_4800   (D2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .bps_select   (bps_select),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(rx_data);
        end
        if (rx_frame_err) e_cyc.push_back(cyc);
        if (rx_valid && rx_frame_err) both_hi <= both_hi + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Cycles from the negedge that drives the start bit to the strobe sample.
    function automatic int lat(input int div);
        return 3 + div / 2 + 9 * div;
    endfunction

    function automatic int vc(input int i);
        return (v_cyc.size() > i) ? v_cyc[i] : -1;
    endfunction

    function automatic int vd(input int i);
        return (v_dat.size() > i) ? int'(v_dat[i]) : -1;
    endfunction

    function automatic int ec(input int i);
        return (e_cyc.size() > i) ? e_cyc[i] : -1;
    endfunction

    // Must be called on a negedge; returns on the negedge that ends the stop bit.
    task automatic send_frame(input logic [7:0] data, input int div, input logic stop_bit,
                              output int t0);
        uart_rx = 1'b0;
        t0 = cyc;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (div) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (div) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset rx_data", rx_data, 8'h00);
        check_eq("reset rx_valid", rx_valid, 1'b0);
        check_eq("reset rx_frame_err", rx_frame_err, 1'b0);
        check_eq("reset rx_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0x55 at 115200: absolute latency 1979 = 1 (to E0) + 1978.
        bps_select = 2'd0;
        send_frame(8'h55, D0, 1'b1, t);
        check_eq("0x55 count", v_cyc.size(), 1);
        check_eq("0x55 data", vd(0), 8'h55);
        check_eq("0x55 latency", vc(0) - t, 1979);
        check_eq("0x55 no ferr", e_cyc.size(), 0);

        // Back-to-back at 9600, stop bit exactly one bit.
        bps_select = 2'd1;
        send_frame(8'hA3, D1, 1'b1, t);
        check_eq("0xA3 latency", vc(1) - t, lat(D1));
        send_frame(8'h0F, D1, 1'b1, t);
        repeat (D1) @(negedge clk);
        check_eq("b2b count", v_cyc.size(), 3);
        check_eq("b2b data0", vd(1), 8'hA3);
        check_eq("b2b data1", vd(2), 8'h0F);
        check_eq("b2b spacing", vc(2) - vc(1), 10 * D1);

        // Framing error then break: line stays low 3 bits after the bad stop bit.
        bps_select = 2'd0;
        send_frame(8'h3C, D0, 1'b0, t);
        repeat (3 * D0) @(negedge clk);
        check_eq("ferr count", e_cyc.size(), 1);
        check_eq("ferr latency", ec(0) - t, 1979);
        check_eq("ferr data kept", rx_data, 8'h0F);
        check_eq("ferr no valid", v_cyc.size(), 3);
        uart_rx = 1'b1;
        repeat (2 * D0) @(negedge clk);
        check_eq("break no ferr", e_cyc.size(), 1);
        send_frame(8'h96, D0, 1'b1, t);
        check_eq("recover data", vd(3), 8'h96);

        // 50-cycle low glitch: busy until the half-bit check at E0+2+104.
        uart_rx = 1'b0;
        t = cyc;
        repeat (50) @(negedge clk);
        uart_rx = 1'b1;
        check_eq("glitch busy", rx_busy, 1'b1);
        repeat (56) @(negedge clk);
        check_eq("glitch busy last", rx_busy, 1'b1);
        @(negedge clk);
        check_eq("glitch idle", rx_busy, 1'b0);
        repeat (D0) @(negedge clk);
        check_eq("glitch no valid", v_cyc.size(), 4);
        check_eq("glitch no ferr", e_cyc.size(), 1);

        // bps_select change mid-frame only affects the next frame.
        bps_select = 2'd0;
        fork
            send_frame(8'hC6, D0, 1'b1, t);
            begin
                repeat (4 * D0) @(negedge clk);
                bps_select = 2'd1;
            end
        join
        check_eq("toggle data", vd(4), 8'hC6);
        check_eq("toggle latency", vc(4) - t, 1979);
        send_frame(8'h3A, D1, 1'b1, t);
        check_eq("next div data", vd(5), 8'h3A);
        check_eq("next div latency", vc(5) - t, lat(D1));

        // Reset in the middle of data bit 4 at 4800.
        bps_select = 2'd2;
        fork
            send_frame(8'hFF, D2, 1'b1, t);
            begin
                repeat (5 * D2 + D2 / 2) @(negedge clk);
                check_eq("pre-reset busy", rx_busy, 1'b1);
                rst_n = 1'b0;
                #1;
                check_eq("mid reset rx_data", rx_data, 8'h00);
                check_eq("mid reset rx_valid", rx_valid, 1'b0);
                check_eq("mid reset rx_frame_err", rx_frame_err, 1'b0);
                check_eq("mid reset rx_busy", rx_busy, 1'b0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        check_eq("abort no valid", v_cyc.size(), 6);
        check_eq("abort no ferr", e_cyc.size(), 1);
        send_frame(8'h81, D2, 1'b1, t);
        check_eq("post reset data", vd(6), 8'h81);
        check_eq("post reset latency", vc(6) - t, lat(D2));
        check_eq("post reset rx_data", rx_data, 8'h81);

        repeat (20) @(negedge clk);
        check_eq("final valid count", v_cyc.size(), 7);
        check_eq("valid/ferr overlap", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
